core_in_unit: RTL

- Upstream feeder for the integer register file's byte-input write port (INE/INDATA/WADDR path). It buffers bytes arriving from the UART receiver in a small FIFO.
- It serves IN instructions from decode: stalls the core until a byte is available, then issues a one-cycle INE pulse. INDATA and the destination address are held stable long enough for the register file's one-cycle-delayed write (`_INE` timing).

---
 rtl/core_pkg.sv | 6 +
 rtl/core_in_unit_if.sv | 30 +++
 rtl/core_in_fifo.sv | 64 ++++++
 rtl/core_in_unit.sv | 107 ++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and widths for the core's byte-input path.
package core_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ISSUE, HOLD} in_state_t;
  localparam int REG_ADDR_W = 5;
  localparam int BYTE_W     = 8;
endpackage

// File: rtl/core_in_unit_if.sv
// Handshake bundle between the UART receiver, decode, the register file and the IN feeder.
interface core_in_unit_if
  import core_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
);
  logic                  RX_VALID;
  logic [BYTE_W-1:0]     RX_DATA;
  logic                  RX_READY;
  logic                  IN_REQ;
  logic [REG_ADDR_W-1:0] IN_RD;
  logic                  STALL;
  logic                  IN_DONE;
  logic                  INE;
  logic [BYTE_W-1:0]     INDATA;
  logic [REG_ADDR_W-1:0] IN_WADDR;
  logic [AW:0]           FIFO_COUNT;
  logic                  OVERFLOW;

  modport master (
    output RX_VALID, RX_DATA, IN_REQ, IN_RD,
    input  RX_READY, STALL, IN_DONE, INE, INDATA, IN_WADDR, FIFO_COUNT, OVERFLOW
  );

  modport slave (
    input  RX_VALID, RX_DATA, IN_REQ, IN_RD,
    output RX_READY, STALL, IN_DONE, INE, INDATA, IN_WADDR, FIFO_COUNT, OVERFLOW
  );
endinterface

// File: rtl/core_in_fifo.sv
// Synchronous byte FIFO; a push while full is dropped and flagged, even if a pop happens the same cycle.
module core_in_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              push_i,
  input  logic [BYTE_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [BYTE_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       count_o,
  output logic              drop_o
);
  localparam int CW = AW + 1;

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign drop_o  = push_i && full_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; occupancy alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/core_in_unit.sv
// Serves IN instructions from buffered UART bytes: stall until a byte exists, pulse INE, hold data for the delayed write.
module core_in_unit
  import core_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST_N,
  core_in_unit_if.slave bus
);
  in_state_t             state_q, state_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  logic [BYTE_W-1:0]     indata_q, indata_d;
  logic                  ine_q, ine_d;
  logic                  done_q, done_d;
  logic                  ovf_q;
  logic                  pop;
  logic [BYTE_W-1:0]     head;
  logic                  full, empty, drop;
  logic [AW:0]           count;

  core_in_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .push_i  (bus.RX_VALID),
    .wdata_i (bus.RX_DATA),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count),
    .drop_o  (drop)
  );

  // The head is popped on the edge that enters ISSUE; IDLE uses IN_RD directly since rd_q is loaded on that same edge.
  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    waddr_d  = waddr_q;
    indata_d = indata_q;
    ine_d    = 1'b0;
    done_d   = 1'b0;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.IN_REQ) begin
          rd_d = bus.IN_RD;
          if (!empty) begin
            pop      = 1'b1;
            ine_d    = 1'b1;
            indata_d = head;
            waddr_d  = bus.IN_RD;
            state_d  = ISSUE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!empty) begin
          pop      = 1'b1;
          ine_d    = 1'b1;
          indata_d = head;
          waddr_d  = rd_q;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        done_d  = 1'b1;
        state_d = HOLD;
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      rd_q     <= '0;
      waddr_q  <= '0;
      indata_q <= '0;
      ine_q    <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      waddr_q  <= waddr_d;
      indata_q <= indata_d;
      ine_q    <= ine_d;
      done_q   <= done_d;
      ovf_q    <= ovf_q | drop;
    end
  end

  assign bus.RX_READY   = !full;
  assign bus.STALL      = bus.IN_REQ && !done_q;
  assign bus.IN_DONE    = done_q;
  assign bus.INE        = ine_q;
  assign bus.INDATA     = indata_q;
  assign bus.IN_WADDR   = waddr_q;
  assign bus.FIFO_COUNT = count;
  assign bus.OVERFLOW   = ovf_q;
endmodule
